op_suma_secuencial: RTL and testbench



---
 rtl/op_suma_secuencial.sv | 136 +++++++++++++
 tb/tb_op_suma_secuencial.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/op_suma_secuencial.sv
// Multi-cycle adder/subtractor: processes K bits per clock with a registered carry
// between chunks. Results and flags are published only when the last chunk completes.
module op_suma_secuencial #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         v,
  output logic         neg,
  output logic         zero,
  output logic [1:0]   state_dbg
);

  // Handshake: start is sampled on a rising edge only in IDLE or DONE; busy is high
  // for exactly N/K cycles after acceptance; done pulses one cycle with results valid.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int NC = N / K;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);

  state_t        state_q;
  logic [N-1:0]  a_q, b_q, res_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;
  logic          busy_q, done_q;
  logic [N-1:0]  sum_q;
  logic          cout_q, v_q, neg_q, zero_q;

  logic [K-1:0]  a_chunk, b_chunk;
  logic [K:0]    chunk_sum;
  logic [N-1:0]  res_d;
  logic          msb_cin;
  logic          last_chunk;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NC; i++) begin
      if (idx_q == IW'(i)) begin
        a_chunk = a_q[i*K +: K];
        b_chunk = b_q[i*K +: K];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{K{1'b0}}, carry_q};
    res_d = res_q;
    for (int i = 0; i < NC; i++) begin
      if (idx_q == IW'(i)) res_d[i*K +: K] = chunk_sum[K-1:0];
    end
    // Carry into the top bit of the chunk, recovered from the sum bit and its addends.
    msb_cin    = a_chunk[K-1] ^ b_chunk[K-1] ^ chunk_sum[K-1];
    last_chunk = (idx_q == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= sub ? ~B : B;
            carry_q <= sub ? 1'b1 : Cin;
            idx_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          res_q   <= res_d;
          carry_q <= chunk_sum[K];
          if (last_chunk) begin
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_d;
            cout_q  <= chunk_sum[K];
            v_q     <= msb_cin ^ chunk_sum[K];
            neg_q   <= res_d[N-1];
            zero_q  <= (res_d == '0);
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign v         = v_q;
  assign neg       = neg_q;
  assign zero      = zero_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_op_suma_secuencial.sv
// Bench for op_suma_secuencial: scenario tasks plus a done-triggered scoreboard
// that compares results against an independent arithmetic model.
module tb_op_suma_secuencial;

  localparam int N   = 8;
  localparam int K   = 4;
  localparam int NC  = N / K;
  localparam int LAT = NC + 1;  // negedges from the start edge to the done observation
  localparam int EW  = N + 4;

  logic         clk = 1'b0;
  logic         rst, start, Cin, sub;
  logic [N-1:0] A, B;
  logic         busy, done, Cout, v, neg, zero;
  logic [N-1:0] Sum;
  logic [1:0]   state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  op_suma_secuencial #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin), .sub(sub),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .v(v), .neg(neg),
    .zero(zero), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Expected {Sum, Cout, v, neg, zero}; overflow uses the sign rule on operands.
  function automatic logic [EW-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic cin, input logic s);
    logic [N-1:0] bop;
    logic [N:0]   full;
    logic [N-1:0] r;
    logic         ov;
    bop  = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bop} + {{N{1'b0}}, (s ? 1'b1 : cin)};
    r    = full[N-1:0];
    ov   = (a[N-1] == bop[N-1]) && (r[N-1] != a[N-1]);
    return {r, full[N], ov, r[N-1], (r == '0)};
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got Sum=%h flags=%b with nothing pending",
                 Sum, {Cout, v, neg, zero});
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({Sum, Cout, v, neg, zero} !== e)
          begin
            n_err++;
            $display("FAIL scoreboard: got Sum=%h CvNZ=%b, expected Sum=%h CvNZ=%b",
                     Sum, {Cout, v, neg, zero}, e[EW-1:4], e[3:0]);
          end
      end
    end
  end

  task automatic drive_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic s, input bit push);
    A = a; B = b; Cin = cin; sub = s; start = 1'b1;
    if (push) exp_q.push_back(model(a, b, cin, s));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_cyc);
    bit seen;
    seen = 0; cyc = -1; busy_cyc = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin
        cyc  = i;
        seen = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_handshake: busy=%b done=%b, expected 0 0", busy, done);
    end
    n_cmp++;
    if (Sum !== '0 || {Cout, v, neg, zero} !== 4'b0000) begin
      n_err++; $display("FAIL reset_outputs: Sum=%h CvNZ=%b, expected 00 0000", Sum, {Cout, v, neg, zero});
    end
    n_cmp++;
    if (state_dbg !== 2'd0) begin
      n_err++; $display("FAIL reset_state: state=%0d, expected 0", state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_overflow();
    int cyc, bc;
    drive_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== LAT || bc !== NC) begin
      n_err++; $display("FAIL add_latency: done_at=%0d busy_cycles=%0d, expected %0d %0d", cyc, bc, LAT, NC);
    end
    n_cmp++;
    if (Sum !== 8'h80 || {Cout, v, neg, zero} !== 4'b0110) begin
      n_err++; $display("FAIL add_7f_01: Sum=%h CvNZ=%b, expected 80 0110", Sum, {Cout, v, neg, zero});
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || Sum !== 8'h80) begin
      n_err++; $display("FAIL done_width: done=%b Sum=%h, expected 0 80 held", done, Sum);
    end
  endtask

  task automatic test_directed_cases();
    logic [N-1:0] ta[4] = '{8'hFF, 8'h0F, 8'h05, 8'h80};
    logic [N-1:0] tb_[4] = '{8'h01, 8'h00, 8'h07, 8'h01};
    logic         tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic         ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [N-1:0] es[4] = '{8'h00, 8'h10, 8'hFE, 8'h7F};
    logic [3:0]   ef[4] = '{4'b1001, 4'b0000, 4'b0010, 4'b1100};
    int cyc, bc;
    for (int i = 0; i < 4; i++) begin
      drive_op(ta[i], tb_[i], tc[i], ts[i], 1'b1);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== LAT) begin
        n_err++; $display("FAIL case%0d_latency: done_at=%0d, expected %0d", i, cyc, LAT);
      end
      n_cmp++;
      if (Sum !== es[i] || {Cout, v, neg, zero} !== ef[i]) begin
        n_err++; $display("FAIL case%0d_result: Sum=%h CvNZ=%b, expected %h %b",
                          i, Sum, {Cout, v, neg, zero}, es[i], ef[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    A = 8'h10; B = 8'h20; Cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
    @(posedge clk);
    // start stays high through BUSY; operand changes here must not disturb the first op
    #1 A = 8'h01; B = 8'h01;
    exp_q.push_back(model(8'h01, 8'h01, 1'b0, 1'b0));
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== LAT || Sum !== 8'h30) begin
      n_err++; $display("FAIL b2b_first: done_at=%0d Sum=%h, expected %0d 30", cyc, Sum, LAT);
    end
    @(posedge clk);
    #1 start = 1'b0; A = 8'hAA; B = 8'h55;
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== LAT - 1 + 1 || bc !== NC || Sum !== 8'h02) begin
      n_err++; $display("FAIL b2b_second: gap=%0d busy_cycles=%0d Sum=%h, expected %0d %0d 02",
                        cyc, bc, Sum, LAT, NC);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'd0 || Sum !== 8'h02) begin
      n_err++; $display("FAIL b2b_idle: state=%0d Sum=%h, expected 0 02", state_dbg, Sum);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc, bc;
    drive_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || Sum !== '0 || {Cout, v, neg, zero} !== 4'b0000) begin
      n_err++; $display("FAIL midop_reset: busy=%b done=%b Sum=%h CvNZ=%b, expected all 0",
                        busy, done, Sum, {Cout, v, neg, zero});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'd0 || Sum !== '0) begin
      n_err++; $display("FAIL midop_no_resume: state=%0d Sum=%h, expected 0 00", state_dbg, Sum);
    end
    drive_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== LAT || Sum !== 8'h80) begin
      n_err++; $display("FAIL midop_recover: done_at=%0d Sum=%h, expected %0d 80", cyc, Sum, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc, bc;
    for (int i = 0; i < 24; i++) begin
      drive_op(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== LAT || bc !== NC) begin
        n_err++; $display("FAIL rand%0d_latency: done_at=%0d busy_cycles=%0d, expected %0d %0d",
                          i, cyc, bc, LAT, NC);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_directed_cases();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL pending_results: %0d left in queue, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
